// File: rtl/match_pkg.sv
// Shared encodings for the match scoreboard: result codes, winner codes and FSM states.
package match_pkg;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_WIN  = 2'b01;
    localparam logic [1:0] RES_LOSE = 2'b10;
    localparam logic [1:0] RES_DRAW = 2'b11;

    localparam logic [1:0] WIN_TIE  = 2'b00;
    localparam logic [1:0] WIN_O    = 2'b01;
    localparam logic [1:0] WIN_P    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage : match_pkg

// File: rtl/match_finish_check.sv
// Combinational finish rule and winner compare on the next (round, win, lose) values.
// Optional feature: define MATCH_SUDDEN_DEATH_EN to extend tied matches past MAX_ROUNDS.
module match_finish_check
    import match_pkg::*;
#(
    parameter int MAX_ROUNDS = 9,
    parameter int CNT_W      = 4
) (
    input  logic [CNT_W-1:0] round,
    input  logic [CNT_W-1:0] win,
    input  logic [CNT_W-1:0] lose,
    output logic             finish,
    output logic [1:0]       winner
);

    localparam logic [CNT_W:0] MAX_X  = MAX_ROUNDS[CNT_W:0];
    localparam logic [CNT_W:0] HARD_X = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W:0] r;
    logic [CNT_W:0] w;
    logic [CNT_W:0] l;
    logic [CNT_W:0] rem;
    logic           early;
    logic           last;

    // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        r     = {1'b0, round};
        w     = {1'b0, win};
        l     = {1'b0, lose};
        // Rounds past MAX_ROUNDS (sudden death only) leave nothing in hand.
        rem   = (r < MAX_X) ? (MAX_X - r) : '0;
        early = (w > (l + rem)) || (l > (w + rem));
`ifdef MATCH_SUDDEN_DEATH_EN
        last  = (r >= MAX_X) && ((w != l) || (r == HARD_X));
`else
        last  = (r == MAX_X);
`endif
        finish = early || last;

        if (w > l) begin
            winner = WIN_P;
        end else if (l > w) begin
            winner = WIN_O;
        end else begin
            winner = WIN_TIE;
        end
    end

endmodule : match_finish_check

// File: rtl/match_scoreboard.sv
// Best-of-N match score keeper: result handshake, round/win/lose counters, match FSM.
// Optional feature: MATCH_SUDDEN_DEATH_EN (see match_finish_check).
module match_scoreboard
    import match_pkg::*;
#(
    parameter int MAX_ROUNDS = 9,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [1:0]       res_code,
    output logic [CNT_W-1:0] round,
    output logic [CNT_W-1:0] win,
    output logic [CNT_W-1:0] lose,
    output logic             fin,
    output logic             fin_pulse,
    output logic [1:0]       winner
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    state_t           state_nx;
    logic             xfer;
    logic             counted;
    logic             finish;
    logic             enter_done;
    logic [CNT_W-1:0] round_nx;
    logic [CNT_W-1:0] win_nx;
    logic [CNT_W-1:0] lose_nx;
    logic [1:0]       winner_nx;

    // start wins over a same-cycle result, so the result is simply not accepted.
    assign res_ready  = (state == PLAY) && !start;
    assign xfer       = res_valid && res_ready;
    assign enter_done = xfer && counted && finish;

    always_comb begin
        round_nx = round;
        win_nx   = win;
        lose_nx  = lose;
        counted  = 1'b0;
        case (res_code)
            RES_WIN: begin
                win_nx   = win + ONE;
                round_nx = round + ONE;
                counted  = 1'b1;
            end
            RES_LOSE: begin
                lose_nx  = lose + ONE;
                round_nx = round + ONE;
                counted  = 1'b1;
            end
            RES_DRAW: begin
                round_nx = round + ONE;
                counted  = 1'b1;
            end
            default: ;
        endcase
    end

    match_finish_check #(
        .MAX_ROUNDS (MAX_ROUNDS),
        .CNT_W      (CNT_W)
    ) u_finish (
        .round  (round_nx),
        .win    (win_nx),
        .lose   (lose_nx),
        .finish (finish),
        .winner (winner_nx)
    );

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = PLAY;
            PLAY: begin
                if (start) begin
                    state_nx = PLAY;
                end else if (enter_done) begin
                    state_nx = DONE;
                end
            end
            DONE: if (start) state_nx = PLAY;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            round     <= '0;
            win       <= '0;
            lose      <= '0;
            fin       <= 1'b0;
            fin_pulse <= 1'b0;
            winner    <= WIN_TIE;
        end else if (start) begin
            round     <= '0;
            win       <= '0;
            lose      <= '0;
            fin       <= 1'b0;
            fin_pulse <= 1'b0;
            winner    <= WIN_TIE;
        end else begin
            fin_pulse <= enter_done;
            if (xfer) begin
                round <= round_nx;
                win   <= win_nx;
                lose  <= lose_nx;
            end
            if (enter_done) begin
                fin    <= 1'b1;
                winner <= winner_nx;
            end
        end
    end

endmodule : match_scoreboard
